// File: rtl/regfile_wb_pkg.sv
// rtl/regfile_wb_pkg.sv - shared constants and entry type for the register-file write-back path
//
// Purpose : constants and the queued-write entry layout shared by
//           regfile_writeback and wb_queue.
// Contents: WB_XLEN / WB_AW / WB_DEPTH / WB_CW constants, wb_entry_t {rd, data}.
// Optional feature macro used by the consumers: REGFILE_WB_FORWARD_EN.

package regfile_wb_pkg;

   localparam int WB_XLEN  = 32;                    // data width
   localparam int WB_AW    = 5;                     // register address width
   localparam int WB_DEPTH = 4;                     // write-queue entries
   localparam int WB_CW    = $clog2(WB_DEPTH) + 1;  // occupancy counter width

   // One pending register-file write.
   typedef struct packed {
      logic [WB_AW-1:0]   rd;
      logic [WB_XLEN-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - circular FIFO of pending register-file writes
//
// Purpose : DEPTH-entry circular queue of wb_entry_t. Besides the usual
//           push/pop interface it exposes every stored entry in age order
//           (index 0 = oldest) with a valid vector, so the parent can build
//           the busy scoreboard and search for forwarding matches.
// Ports   : clk, rst_n (async active-low)
//           push, push_entry   - enqueue (ignored while full)
//           pop                - dequeue head (ignored while empty)
//           head               - oldest entry
//           full, empty, count - registered occupancy state
//           age_entry, age_valid - entries oldest-first, valid per slot
// Used with or without REGFILE_WB_FORWARD_EN; the queue itself has no option.

module wb_queue
   import regfile_wb_pkg::*;
#(
   parameter int  DEPTH = WB_DEPTH,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  wb_entry_t        push_entry,
   input  logic             pop,
   output wb_entry_t        head,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count,
   output wb_entry_t        age_entry [DEPTH],
   output logic [DEPTH-1:0] age_valid
);

   wb_entry_t        mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: a slot is only observed while it is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_entry;
   end

   // Rotate storage so slot k is the k-th oldest entry.
   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         age_entry[k] = mem[rd_ptr + PW'(k)];
         age_valid[k] = (CW'(k) < count);
      end
   end

endmodule

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - write-side controller for the 32x32 register file
//
// Purpose : accepts destination writes from the load unit (priority) and the
//           ALU, queues them, and drives the single register-file write port
//           one entry per cycle through a registered output stage. Publishes a
//           busy scoreboard of registers with pending writes.
// Ports   : clk, rst (async active-low)
//           ld_valid/ld_ready/ld_rd/ld_data      - load write request
//           alu_valid/alu_ready/alu_rd/alu_data  - ALU write request
//           wb_stall                             - hold the queue head
//           reg_write/wr_rd/wr_data              - registered write port
//           busy_mask                            - registers with pending writes
//           q_count                              - queue occupancy
// Option  : REGFILE_WB_FORWARD_EN adds fwd_rs1/fwd_rs2 lookups returning
//           fwd_hit1/fwd_hit2 and fwd_data1/fwd_data2 (youngest pending value).
// The entry layout comes from regfile_wb_pkg; XLEN/AW must match it.

module regfile_writeback
   import regfile_wb_pkg::*;
#(
   parameter int  XLEN  = WB_XLEN,
   parameter int  AW    = WB_AW,
   parameter int  DEPTH = WB_DEPTH,
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            alu_valid,
   output logic            alu_ready,
   input  logic [AW-1:0]   alu_rd,
   input  logic [XLEN-1:0] alu_data,
   input  logic            ld_valid,
   output logic            ld_ready,
   input  logic [AW-1:0]   ld_rd,
   input  logic [XLEN-1:0] ld_data,
   input  logic            wb_stall,
   output logic            reg_write,
   output logic [AW-1:0]   wr_rd,
   output logic [XLEN-1:0] wr_data,
   output logic [31:0]     busy_mask,
   output logic [CW-1:0]   q_count
`ifdef REGFILE_WB_FORWARD_EN
   ,
   input  logic [AW-1:0]   fwd_rs1,
   input  logic [AW-1:0]   fwd_rs2,
   output logic            fwd_hit1,
   output logic            fwd_hit2,
   output logic [XLEN-1:0] fwd_data1,
   output logic [XLEN-1:0] fwd_data2
`endif
);

   wb_entry_t        push_entry;
   wb_entry_t        head;
   wb_entry_t        age_entry [DEPTH];
   logic [DEPTH-1:0] age_valid;
   logic             full;
   logic             empty;
   logic             ld_fire;
   logic             alu_fire;
   logic             push;
   logic             pop;

   // Readies use only the registered full flag: a pop this cycle does not
   // reopen the queue until the count has updated.
   assign ld_ready  = rst && !full;
   assign alu_ready = rst && !full && !ld_valid;
   assign ld_fire   = ld_valid && ld_ready;
   assign alu_fire  = alu_valid && alu_ready;

   always_comb begin
      push_entry = '{rd: alu_rd, data: alu_data};
      if (ld_fire) push_entry = '{rd: ld_rd, data: ld_data};
   end

   // x0 writes complete their handshake but are dropped here.
   assign push = (ld_fire && (ld_rd != '0)) || (alu_fire && (alu_rd != '0));
   assign pop  = !empty && !wb_stall;

   wb_queue #(.DEPTH(DEPTH)) u_queue (
      .clk        (clk),
      .rst_n      (rst),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .head       (head),
      .full       (full),
      .empty      (empty),
      .count      (q_count),
      .age_entry  (age_entry),
      .age_valid  (age_valid)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         reg_write <= 1'b0;
         wr_rd     <= '0;
         wr_data   <= '0;
      end else begin
         reg_write <= pop;
         if (pop) begin
            wr_rd   <= head.rd;
            wr_data <= head.data;
         end
      end
   end

   // A register stays busy until its last queued write has been presented.
   always_comb begin
      busy_mask = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (age_valid[k]) busy_mask[age_entry[k].rd] = 1'b1;
      end
      if (reg_write) busy_mask[wr_rd] = 1'b1;
      busy_mask[0] = 1'b0;
   end

`ifdef REGFILE_WB_FORWARD_EN
   logic [AW-1:0]   fwd_rs   [2];
   logic [1:0]      fwd_hit;
   logic [XLEN-1:0] fwd_data [2];

   assign fwd_rs[0] = fwd_rs1;
   assign fwd_rs[1] = fwd_rs2;

   // Oldest first (output register, then queue head to tail) so the
   // youngest match overwrites earlier ones.
   always_comb begin
      for (int j = 0; j < 2; j++) begin
         fwd_hit[j]  = 1'b0;
         fwd_data[j] = '0;
         if (reg_write && (wr_rd == fwd_rs[j])) begin
            fwd_hit[j]  = 1'b1;
            fwd_data[j] = wr_data;
         end
         for (int k = 0; k < DEPTH; k++) begin
            if (age_valid[k] && (age_entry[k].rd == fwd_rs[j])) begin
               fwd_hit[j]  = 1'b1;
               fwd_data[j] = age_entry[k].data;
            end
         end
         if (fwd_rs[j] == '0) begin
            fwd_hit[j]  = 1'b0;
            fwd_data[j] = '0;
         end
      end
   end

   assign fwd_hit1  = fwd_hit[0];
   assign fwd_hit2  = fwd_hit[1];
   assign fwd_data1 = fwd_data[0];
   assign fwd_data2 = fwd_data[1];
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - self-checking bench for regfile_writeback
//
// Reference model: an ordered list of pending writes plus the presented
// output write; readiness, occupancy, scoreboard and forwarding are derived
// from that list. Works with or without REGFILE_WB_FORWARD_EN.

module tb_regfile_writeback;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid, ld_valid, wb_stall;
   logic        alu_ready, ld_ready;
   logic [4:0]  alu_rd, ld_rd;
   logic [31:0] alu_data, ld_data;
   logic        reg_write;
   logic [4:0]  wr_rd;
   logic [31:0] wr_data;
   logic [31:0] busy_mask;
   logic [2:0]  q_count;
`ifdef REGFILE_WB_FORWARD_EN
   logic [4:0]  fwd_rs1, fwd_rs2;
   logic        fwd_hit1, fwd_hit2;
   logic [31:0] fwd_data1, fwd_data2;
`endif

   always #5 clk = ~clk;

   regfile_writeback dut (
      .clk       (clk),
      .rst       (rst),
      .alu_valid (alu_valid),
      .alu_ready (alu_ready),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .ld_valid  (ld_valid),
      .ld_ready  (ld_ready),
      .ld_rd     (ld_rd),
      .ld_data   (ld_data),
      .wb_stall  (wb_stall),
      .reg_write (reg_write),
      .wr_rd     (wr_rd),
      .wr_data   (wr_data),
      .busy_mask (busy_mask),
      .q_count   (q_count)
`ifdef REGFILE_WB_FORWARD_EN
      ,
      .fwd_rs1   (fwd_rs1),
      .fwd_rs2   (fwd_rs2),
      .fwd_hit1  (fwd_hit1),
      .fwd_hit2  (fwd_hit2),
      .fwd_data1 (fwd_data1),
      .fwd_data2 (fwd_data2)
`endif
   );

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   ent_t        mq[$];          // pending writes, oldest first
   logic        m_rw;           // write presented this cycle
   logic [4:0]  m_rd;
   logic [31:0] m_data;
   int          total = 0;
   int          bad   = 0;
   bit          obs_alu_ready;
   bit          rand_fwd = 1'b1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_busy();
      logic [31:0] b = '0;
      foreach (mq[i]) b[mq[i].rd] = 1'b1;
      if (m_rw) b[m_rd] = 1'b1;
      b[0] = 1'b0;
      return b;
   endfunction

   function automatic logic [32:0] exp_fwd(input logic [4:0] rs);
      if (rs == 5'd0) return 33'h0;
      for (int i = mq.size() - 1; i >= 0; i--)
         if (mq[i].rd == rs) return {1'b1, mq[i].data};
      if (m_rw && m_rd == rs) return {1'b1, m_data};
      return 33'h0;
   endfunction

   task automatic model_clear();
      mq.delete();
      m_rw   = 1'b0;
      m_rd   = '0;
      m_data = '0;
   endtask

   // One clock: drive at posedge+1, check at negedge, advance model at posedge.
   task automatic step(input bit lv, input logic [4:0] lr, input logic [31:0] ldd,
                       input bit av, input logic [4:0] ar, input logic [31:0] ad,
                       input bit st);
      bit   full_m, la, aa;
      ent_t e;
      ld_valid = lv;  ld_rd = lr;  ld_data = ldd;
      alu_valid = av; alu_rd = ar; alu_data = ad;
      wb_stall = st;
`ifdef REGFILE_WB_FORWARD_EN
      if (rand_fwd) begin
         fwd_rs1 = 5'($urandom_range(0, 7));
         fwd_rs2 = 5'($urandom_range(0, 7));
      end
`endif
      @(negedge clk);
      full_m = (mq.size() == DEPTH);
      chk("ld_ready",  ld_ready,  !full_m);
      chk("alu_ready", alu_ready, !full_m && !lv);
      chk("reg_write", reg_write, m_rw);
      chk("wr_rd",     wr_rd,     m_rd);
      chk("wr_data",   wr_data,   m_data);
      chk("busy_mask", busy_mask, exp_busy());
      chk("q_count",   q_count,   mq.size());
`ifdef REGFILE_WB_FORWARD_EN
      chk("fwd1", {fwd_hit1, fwd_data1}, exp_fwd(fwd_rs1));
      chk("fwd2", {fwd_hit2, fwd_data2}, exp_fwd(fwd_rs2));
`endif
      obs_alu_ready = alu_ready;
      la = lv && !full_m;
      aa = av && !full_m && !lv;
      @(posedge clk);
      if (mq.size() > 0 && !st) begin
         e = mq.pop_front();
         m_rw = 1'b1; m_rd = e.rd; m_data = e.data;
      end else begin
         m_rw = 1'b0;
      end
      if (la && lr != 5'd0)      mq.push_back('{rd: lr, data: ldd});
      else if (aa && ar != 5'd0) mq.push_back('{rd: ar, data: ad});
      #1;
   endtask

   task automatic idle(input int n, input bit st);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, st);
   endtask

   // Asynchronous reset asserted mid-cycle with requests still valid.
   task automatic reset_check(input string tag);
      #2 rst = 1'b0;
      ld_valid = 1'b1; ld_rd = 5'd9; alu_valid = 1'b1; alu_rd = 5'd10;
      #1;
      chk({tag, "_reg_write"}, reg_write, 1'b0);
      chk({tag, "_wr_rd"},     wr_rd,     5'd0);
      chk({tag, "_wr_data"},   wr_data,   32'd0);
      chk({tag, "_busy"},      busy_mask, 32'd0);
      chk({tag, "_q_count"},   q_count,   3'd0);
      chk({tag, "_ld_ready"},  ld_ready,  1'b0);
      chk({tag, "_alu_ready"}, alu_ready, 1'b0);
      @(posedge clk); #1;
      chk({tag, "_q_count_held"}, q_count, 3'd0);
      @(negedge clk);
      rst = 1'b1; ld_valid = 1'b0; alu_valid = 1'b0;
      model_clear();
      @(posedge clk); #1;
   endtask

   initial begin
      int cnt;
      int guard;
      rst = 1'b0;
      ld_valid = 0; alu_valid = 0; wb_stall = 0;
      ld_rd = 0; alu_rd = 0; ld_data = 0; alu_data = 0;
`ifdef REGFILE_WB_FORWARD_EN
      fwd_rs1 = 0; fwd_rs2 = 0;
`endif
      model_clear();
      @(posedge clk); @(posedge clk); #1;
      reset_check("por");

      // Single ALU write rd5.
      step(0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 0);
      idle(3, 0);

      // Load and ALU together: load wins, ALU retried next cycle.
      step(1, 5'd3, 32'h3333_0003, 1, 5'd4, 32'h4444_0004, 0);
      step(0, 0, 0, 1, 5'd4, 32'h4444_0004, 0);
      idle(3, 0);

      // Stall: five pushes into a four-deep queue.
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 1, 5'(11 + i), 32'hA000 + 32'(i), 1);
         if (obs_alu_ready) cnt++;
      end
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 1, 5'd15, 32'hA004, 1);
         if (obs_alu_ready) cnt++;
      end
      chk("stall_accept_cnt", cnt, 4);
      guard = 0;
      do begin
         step(0, 0, 0, 1, 5'd15, 32'hA004, 0);
         guard++;
      end while (!obs_alu_ready && guard < 10);
      chk("stall_fifth_accepted", obs_alu_ready, 1'b1);
      idle(7, 0);

      // x0 write: handshake only.
      step(0, 0, 0, 1, 5'd0, 32'h1234, 0);
      idle(3, 0);

`ifdef REGFILE_WB_FORWARD_EN
      // Two writes to rd7 held in the queue: youngest value forwarded.
      step(0, 0, 0, 1, 5'd7, 32'h11, 1);
      step(0, 0, 0, 1, 5'd7, 32'h22, 1);
      rand_fwd = 1'b0;
      fwd_rs1 = 5'd7; fwd_rs2 = 5'd0;
      step(0, 0, 0, 0, 0, 0, 1);
      chk("fwd_rd7", {fwd_hit1, fwd_data1}, {1'b1, 32'h22});
      chk("fwd_x0",  fwd_hit2, 1'b0);
      rand_fwd = 1'b1;
      idle(4, 0);
`endif

      // Reset mid-stream with three entries queued.
      step(0, 0, 0, 1, 5'd1, 32'h1, 1);
      step(1, 5'd2, 32'h2, 0, 0, 0, 1);
      step(0, 0, 0, 1, 5'd3, 32'h3, 1);
      chk("pre_reset_count", q_count, 3'd3);
      reset_check("mid");
      idle(2, 0);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom,
              ($urandom_range(0, 1) == 0), 5'($urandom_range(0, 7)), $urandom,
              ($urandom_range(0, 3) == 0));
      end
      idle(8, 0);
      chk("final_empty", q_count, 3'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-side controller for the 32x32 register file: collects destination writes from the ALU and load unit, queues them, and drives the file's single write port one entry per cycle. Sits between the execute/memory stages and the register file. Publishes a scoreboard of registers with pending writes so issue logic can hold dependent instructions.

## Interface
Parameters:
- XLEN, 32, data width
- AW, 5, register address width (32 registers)
- DEPTH, 4, write-queue entries (power of two, >=2)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU write request
- alu_ready  out  1  ALU request accepted this cycle when high with alu_valid
- alu_rd  in  AW  ALU destination
- alu_data  in  XLEN  ALU result
- ld_valid  in  1  load write request
- ld_ready  out  1  load request accepted this cycle when high with ld_valid
- ld_rd  in  AW  load destination
- ld_data  in  XLEN  load data
- wb_stall  in  1  register-file write port unavailable; hold queue head
- reg_write  out  1  write enable to register file (registered)
- wr_rd  out  AW  write address (registered)
- wr_data  out  XLEN  write data (registered)
- busy_mask  out  32  bit i set while any queued or presented write targets register i
- q_count  out  log2(DEPTH)+1  queue occupancy

## Operation
- Clock is clk. Reset is asynchronous and active-low on rst.
- Arbitration: fixed priority, load over ALU. ld_ready = rst && !full. alu_ready = rst && !full && !ld_valid. At most one push per cycle.
- Writes with rd==0 are handshaken normally but never enqueued; x0 is never written, never appears in busy_mask.
- Pop: when queue non-empty and wb_stall==0, head moves into output register: reg_write<=1, wr_rd/wr_data<=head. Otherwise reg_write<=0; wr_rd/wr_data hold.
- full = (q_count==DEPTH), using registered count; a pop in the same cycle does not make ready high (no combinational pop-to-ready path).
- Simultaneous push and pop: count unchanged, pointers both advance.
- Pointers wrap modulo DEPTH.
- busy_mask = OR of one-hot(rd) over valid entries plus wr_rd when reg_write==1. Two queued writes to same rd: bit stays set until the last retires. Entries retire in push order.
- Reset (any time, including mid-drain): queue empties, pointers and count 0, reg_write=0, wr_rd=0, wr_data=0, busy_mask=0, both readies 0 while rst low. Queued data is discarded.

## Timing
- Request accepted at edge N into empty queue, wb_stall low -> reg_write high during cycle N+1 through the register, file updated at edge N+2 (latency 2 edges).
- Sustained throughput 1 write/cycle while wb_stall low.
- wb_stall high freezes head; accepts continue until full.
- busy_mask bit set combinationally from cycle after acceptance; clears in cycle after the retiring write's reg_write cycle.

## Configuration
- REGFILE_WB_FORWARD_EN defined: adds inputs fwd_rs1, fwd_rs2 (AW) and outputs fwd_hit1, fwd_hit2 (1), fwd_data1, fwd_data2 (XLEN); combinational search of presented output register then queue, returning the youngest matching entry; rs==0 never hits.
- Undefined: ports absent; consumers rely on busy_mask stalls only.

## Structure
- Shared package regfile_wb_pkg: XLEN, AW, DEPTH constants, wb_entry_t struct {rd, data}, count width constant.
- One sub-module wb_queue: circular FIFO of wb_entry_t with push/pop/full/empty/count and per-entry valid vector for mask and forward search.

## Test plan
- Reset: rst low mid-stream with 3 entries queued -> reg_write=0, busy_mask=0, q_count=0, readies 0; after release, readies 1.
- Single ALU write rd=5, data=0xDEADBEEF -> reg_write pulse 1 cycle later, wr_rd=5, busy_mask[5] set then cleared.
- ld_valid and alu_valid same cycle (rd 3 / rd 4) -> load accepted, alu_ready=0; next cycle ALU accepted; writes retire rd3 then rd4.
- wb_stall high, push 5 writes with DEPTH=4 -> 4 accepted, 5th sees ready=0 until stall drops; retire order preserved.
- Write to rd=0 with data 0x1234 -> handshake completes, reg_write never asserts, busy_mask[0]=0.
- With REGFILE_WB_FORWARD_EN: queue rd7=0x11 then rd7=0x22, stall held -> fwd_rs1=7 gives hit1=1, data1=0x22.
